// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: BCD digit type, active-low {g..a} patterns
// and the decode function used by every display block.
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Values 10..15 fall to blank so a corrupt digit never lights anything.
  function automatic logic [6:0] seg7_decode_f(input bcd_t d, input logic blank);
    logic [6:0] s;
    s = SEG_BLANK;
    if (!blank) begin
      case (d)
        4'd0:    s = SEG_0;
        4'd1:    s = SEG_1;
        4'd2:    s = SEG_2;
        4'd3:    s = SEG_3;
        4'd4:    s = SEG_4;
        4'd5:    s = SEG_5;
        4'd6:    s = SEG_6;
        4'd7:    s = SEG_7;
        4'd8:    s = SEG_8;
        4'd9:    s = SEG_9;
        default: s = SEG_BLANK;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Digit load side and display pin side of the seg7_scan block.
// load is a one-cycle strobe sampled on each rising clk edge with bcd_in/dp_in;
// there is no back-pressure, so every strobe is captured.
interface seg7_scan_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic [6:0]          seg_n;
  logic                dp_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame_start;

  modport master (
    output bcd_in, dp_in, load,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  bcd_in, dp_in, load,
    output seg_n, dp_n, an_n, frame_start
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decoder with a blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = seg7_decode_f(digit_i, blank_i);

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment scanner with double-buffered digits.
// Build option: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000
) (
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] shadow_bcd_q, disp_bcd_q;
  logic [DIGITS-1:0]   shadow_dp_q, disp_dp_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                fs_q;

  logic                tick, frame_edge;
  bcd_t                cur_digit;
  logic                cur_dp, cur_blank;
  logic [DIGITS-1:0]   blank_mask;
  logic [DIGITS-1:0]   an_d;
  logic [6:0]          seg_d;

  assign tick       = (pre_q == PRE_MAX);
  assign frame_edge = tick && (idx_q == IDX_MAX);

`ifdef SEG7_LZB_EN
  // Digit i>0 blanks when it and every digit above it are zero; built from
  // the display register so the mask only moves at frame boundaries.
  logic zero_above;
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (disp_bcd_q[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = disp_bcd_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = blank_mask[i];
        an_d[i]   = 1'b0;
      end
    end
  end

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_n_o (seg_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      disp_bcd_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fs_q         <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick) idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      if (bus.load) begin
        shadow_bcd_q <= bus.bcd_in;
        shadow_dp_q  <= bus.dp_in;
      end
      // A load coinciding with the boundary bypasses the shadow so it is not lost a frame.
      if (frame_edge) begin
        disp_bcd_q <= bus.load ? bus.bcd_in : shadow_bcd_q;
        disp_dp_q  <= bus.load ? bus.dp_in  : shadow_dp_q;
      end
      seg_q <= seg_d;
      dp_q  <= ~cur_dp;
      an_q  <= an_d;
      fs_q  <= frame_edge;
    end
  end

  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.an_n        = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed plus randomized bench for seg7_scan (DIGITS=4, SCAN_DIV=4) against
// a cycle-count based reference model; honours SEG7_LZB_EN.
module tb_seg7_scan;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;
  localparam int W        = 13;  // {frame_start, an_n[3:0], dp_n, seg_n[6:0]}

  logic clk = 1'b0;
  logic reset;

  seg7_scan_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [16];
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_dp_shadow, m_dp_disp;
  int          k;  // edges since reset release
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] model_out();
    int          slot;
    logic [3:0]  d;
    logic        blank;
    logic [6:0]  s;
    logic [3:0]  an;
    slot  = ((k - 1) / SCAN_DIV) % DIGITS;
    d     = m_disp[4*slot +: 4];
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    blank = (slot > 0) && ((m_disp >> (4 * slot)) == 16'd0);
`endif
    s  = blank ? 7'b1111111 : seg_tab[d];
    an = ~(4'b0001 << slot);
    return {(k >= FRAME) && (k % FRAME == 0), an, ~m_dp_disp[slot], s};
  endfunction

  // ---------------- checks ----------------
  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (bus.seg_n === e[6:0]) else begin
      errors++;
      $error("FAIL %s seg_n k=%0d got %b exp %b", tag, k, bus.seg_n, e[6:0]);
    end
    checks++;
    assert (bus.dp_n === e[7]) else begin
      errors++;
      $error("FAIL %s dp_n k=%0d got %b exp %b", tag, k, bus.dp_n, e[7]);
    end
    checks++;
    assert (bus.an_n === e[11:8]) else begin
      errors++;
      $error("FAIL %s an_n k=%0d got %b exp %b", tag, k, bus.an_n, e[11:8]);
    end
    checks++;
    assert (bus.frame_start === e[12]) else begin
      errors++;
      $error("FAIL %s frame_start k=%0d got %b exp %b", tag, k, bus.frame_start, e[12]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    assert ({bus.frame_start, bus.an_n, bus.dp_n, bus.seg_n} === 13'b0_1111_1_1111111) else begin
      errors++;
      $error("FAIL %s reset outputs got fs=%b an=%b dp=%b seg=%b exp fs=0 an=1111 dp=1 seg=1111111",
             tag, bus.frame_start, bus.an_n, bus.dp_n, bus.seg_n);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk_step(input logic ld, input logic [15:0] b, input logic [3:0] d,
                          input string tag);
    bus.load   = ld;
    bus.bcd_in = b;
    bus.dp_in  = d;
    @(posedge clk);
    k++;
    exp_q.push_back(model_out());
    if (k % FRAME == 0) begin
      m_disp    = ld ? b : m_shadow;
      m_dp_disp = ld ? d : m_dp_shadow;
    end
    if (ld) begin
      m_shadow    = b;
      m_dp_shadow = d;
    end
    #1;
    check_outputs(tag);
  endtask

  // Inputs wiggle randomly while load is low to show they are ignored.
  task automatic idle_until(input int target, input string tag);
    while (k < target)
      clk_step(1'b0, 16'($urandom), 4'($urandom), tag);
  endtask

  task automatic load_at(input int edge_no, input logic [15:0] b, input logic [3:0] d,
                         input string tag);
    idle_until(edge_no - 1, tag);
    clk_step(1'b1, b, d, tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    m_shadow = '0; m_disp = '0; m_dp_shadow = '0; m_dp_disp = '0;
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    bus.dp_in  = '0;
    reset      = 1'b1;
    k          = 0;
    #1;
    check_reset_vals("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    release_reset();

    idle_until(32, "scan_zero");
    load_at(36, 16'h1234, 4'b0000, "load_mid_frame");
    idle_until(80, "show_1234");
    load_at(85, 16'h9999, 4'b1111, "shadow_9999");
    load_at(96, 16'h5678, 4'b0010, "load_on_boundary");
    idle_until(128, "show_5678");
    load_at(130, 16'hABCF, 4'b0101, "load_invalid");
    idle_until(176, "show_blank_dp");
    load_at(178, 16'h1234, 4'b0000, "reload_1234");
    idle_until(202, "digit2_of_1234");

    #2 reset = 1'b1;
    #1;
    check_reset_vals("reset_async_mid_frame");
    release_reset();
    idle_until(40, "after_reset_zero");

    load_at(42, 16'h0090, 4'b0000, "load_0090");
    idle_until(80, "show_0090");
    load_at(82, 16'h0000, 4'b1000, "load_0000");
    idle_until(112, "show_0000");

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0)
        clk_step(1'b1, 16'($urandom), 4'($urandom), "random_load");
      else if ($urandom_range(0, 15) == 0)
        clk_step(1'b1, {4'd0, 4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                 4'($urandom), "random_small");
      else
        clk_step(1'b0, 16'($urandom), 4'($urandom), "random_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
